pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
- Sequencing controller for the decode/execute/memory datapath.
- Tracks in-flight instructions in the EX and MEM slots with a small scoreboard.
- Generates operand-forwarding selects, load-use stalls, branch flushes and a memory request/acknowledge handshake with freeze and timeout.
- Sits beside the datapath; its outputs drive the pipeline-register enables, the bubble inserts and the forwarding muxes.

Parameters:
- MEM_TIMEOUT, 16: cycles waited for mem_ack before abort (range 2..255).
- CNT_W, 16: width of the stall performance counter.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active-high
- dec_valid  input  1  decode stage holds a valid instruction
- dec_rs1  input  5  source register 1 of the decode instruction
- dec_rs2  input  5  source register 2 of the decode instruction
- dec_use_rs1  input  1  decode instruction reads rs1
- dec_use_rs2  input  1  decode instruction reads rs2
- dec_rd  input  5  destination register of the decode instruction
- dec_rf_wb  input  1  decode instruction writes the register file
- dec_is_load  input  1  decode instruction is a load
- dec_is_store  input  1  decode instruction is a store
- branch_taken_ex  input  1  EX-slot instruction redirects the PC
- mem_ack  input  1  data memory completes the current access
- stall_fe  output  1  hold the PC and the IF/DEC register
- bubble_ex  output  1  load a NOP into the DEC/EX register
- flush_dec  output  1  kill the fetched/decode instruction
- freeze  output  1  hold every pipeline register
- mem_req  output  1  data memory access request
- mem_err  output  1  sticky memory-timeout flag
- fwd_a  output  2  rs1 operand select: 00 regfile, 01 EX result, 10 MEM result
- fwd_b  output  2  rs2 operand select, same encoding as fwd_a
- stall_cnt  output  CNT_W  count of stall/freeze cycles, saturating

Behaviour:
- Reset (async, active-high): all scoreboard slots invalid, FSM in IDLE, all outputs 0, stall_cnt 0, mem_err 0.
- Scoreboard slot fields: {valid, rd, rf_wb, is_load, is_mem}, one slot for EX and one for MEM.
- Slot advance, when not frozen:
  - MEM slot <= EX slot.
  - EX slot <= decode fields if dec_valid && !bubble_ex && !flush_dec; otherwise EX slot becomes invalid.
- Hazard match: slot valid && rf_wb && rd != 0 && rd == rs && use_rs. Register x0 never matches.
- Forwarding (combinational, per operand):
  - EX-slot match (non-load) -> 01.
  - Else MEM-slot match -> 10.
  - Else 00.
  - EX has priority over MEM.
- Load-use hazard: EX-slot match where EX.is_load = 1.
  - stall_fe=1 and bubble_ex=1 for exactly 1 cycle.
  - Next cycle the load is in MEM and the operand forwards with select 10.
- Branch: branch_taken_ex=1 while not frozen -> flush_dec=1 for 1 cycle and the decode instruction does not enter EX.
  - flush overrides load-use: on simultaneous events stall_fe=0 and bubble_ex=0.
- Memory FSM, states IDLE, WAIT:
  - IDLE -> WAIT on the cycle the MEM slot becomes valid with is_mem=1, i.e. the registered slot after advance.
  - In WAIT: mem_req=1 and freeze=1 unless mem_ack is high that cycle.
  - mem_ack in WAIT -> IDLE; mem_req drops the next cycle. freeze is 0 in the ack cycle, so the pipeline advances.
  - Back-to-back memory ops: IDLE is re-entered for 0 cycles. If the next MEM slot is also a mem op, WAIT is re-entered immediately and mem_req stays high.
  - Timeout counter resets on WAIT entry and increments each WAIT cycle. On reaching MEM_TIMEOUT without ack: mem_err <= 1 (sticky until reset), FSM -> IDLE, access abandoned, pipeline released.
  - mem_ack in IDLE is ignored.
- While frozen, branch_taken_ex and the load-use detection outputs are masked (flush_dec=0, bubble_ex=0) and the slots hold.
- freeze implies stall_fe=1.
- stall_cnt increments on any cycle with stall_fe=1 and saturates at all-ones.
- Reset asserted mid-WAIT: immediate return to IDLE with mem_req=0. An ack arriving after reset is ignored.

Test Plan:
- Load x5 in EX, decode reads rs1=x5 -> 1 cycle of stall_fe=1 and bubble_ex=1, then fwd_a=10. stall_cnt=1.
- ADD writing x3, then consecutive SUB reading x3 as rs2 -> fwd_b=01, no stall. Two instructions later fwd_b=10.
- Instruction writing x0 followed by a reader of x0 -> fwd_a=00, no stall.
- branch_taken_ex=1 coinciding with a load-use match -> flush_dec=1, stall_fe=0, bubble_ex=0. The EX slot is invalid the next cycle.
- Store reaches MEM with mem_ack delayed 3 cycles -> mem_req high 4 cycles, freeze high 3 cycles, stall_cnt=3. Back-to-back loads keep mem_req continuously high.
- MEM_TIMEOUT=4 and mem_ack never asserted -> mem_err=1 after 4 WAIT cycles, FSM returns to IDLE and freeze drops. Async rst then clears mem_err to 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the decode/execute/memory datapath and its hazard controller.
// The datapath side uses master and the controller uses slave.
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic             dec_valid;
    logic [4:0]       dec_rs1;
    logic [4:0]       dec_rs2;
    logic             dec_use_rs1;
    logic             dec_use_rs2;
    logic [4:0]       dec_rd;
    logic             dec_rf_wb;
    logic             dec_is_load;
    logic             dec_is_store;
    logic             branch_taken_ex;
    logic             mem_ack;
    logic             stall_fe;
    logic             bubble_ex;
    logic             flush_dec;
    logic             freeze;
    logic             mem_req;
    logic             mem_err;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output dec_valid, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2, dec_rd,
               dec_rf_wb, dec_is_load, dec_is_store, branch_taken_ex, mem_ack,
        input  stall_fe, bubble_ex, flush_dec, freeze, mem_req, mem_err,
               fwd_a, fwd_b, stall_cnt
    );

    modport slave (
        input  dec_valid, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2, dec_rd,
               dec_rf_wb, dec_is_load, dec_is_store, branch_taken_ex, mem_ack,
        output stall_fe, bubble_ex, flush_dec, freeze, mem_req, mem_err,
               fwd_a, fwd_b, stall_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller: EX/MEM scoreboard, operand forwarding, load-use stall,
// branch flush and a memory request/ack handshake with freeze and timeout.
module pipeline_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    pipeline_hazard_ctrl_if.slave bus
);
    localparam int unsigned TO_W = 8;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       rf_wb;
        logic       is_load;
        logic       is_mem;
    } slot_t;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    slot_t            r_ex;
    slot_t            r_mem;
    slot_t            w_dec_slot;
    logic [TO_W-1:0]  r_tcnt;
    logic             r_mem_err;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_freeze;
    logic             w_mem_req;
    logic             w_timeout;
    logic             w_wait_entry;
    logic             w_flush;
    logic             w_bubble;
    logic             w_stall;
    logic             w_load_use;
    logic [1:0]       w_fwd_a;
    logic [1:0]       w_fwd_b;
    logic             w_unused;

    function automatic logic hit(input slot_t s, input logic [4:0] rs, input logic use_rs);
        return s.valid && s.rf_wb && (s.rd != 5'd0) && (s.rd == rs) && use_rs;
    endfunction

    // A load in EX has no result yet, so it falls through to the MEM check.
    function automatic logic [1:0] fwd_sel(input slot_t ex, input slot_t mem,
                                           input logic [4:0] rs, input logic use_rs);
        if (hit(ex, rs, use_rs) && !ex.is_load) return 2'b01;
        if (hit(mem, rs, use_rs))               return 2'b10;
        return 2'b00;
    endfunction

    assign w_dec_slot = '{valid:   1'b1,
                          rd:      bus.dec_rd,
                          rf_wb:   bus.dec_rf_wb,
                          is_load: bus.dec_is_load,
                          is_mem:  bus.dec_is_load | bus.dec_is_store};

    assign w_fwd_a    = fwd_sel(r_ex, r_mem, bus.dec_rs1, bus.dec_use_rs1);
    assign w_fwd_b    = fwd_sel(r_ex, r_mem, bus.dec_rs2, bus.dec_use_rs2);
    assign w_load_use = bus.dec_valid && r_ex.is_load &&
                        (hit(r_ex, bus.dec_rs1, bus.dec_use_rs1) ||
                         hit(r_ex, bus.dec_rs2, bus.dec_use_rs2));
    assign w_unused   = r_mem.is_load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // WAIT is entered on the same edge that advances a memory op into MEM.
    always_comb begin
        w_state_nxt  = r_state;
        w_freeze     = 1'b0;
        w_mem_req    = 1'b0;
        w_timeout    = 1'b0;
        w_wait_entry = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_ex.valid && r_ex.is_mem) begin
                    w_state_nxt  = WAIT;
                    w_wait_entry = 1'b1;
                end
            end
            WAIT: begin
                w_mem_req = r_mem.valid && r_mem.is_mem;
                if (bus.mem_ack) begin
                    if (r_ex.valid && r_ex.is_mem) w_wait_entry = 1'b1;
                    else                           w_state_nxt  = IDLE;
                end else begin
                    w_freeze = 1'b1;
                    if (r_tcnt == TO_W'(MEM_TIMEOUT - 1)) begin
                        w_timeout   = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        w_flush  = bus.branch_taken_ex && !w_freeze;
        w_bubble = w_load_use && !w_freeze && !w_flush;
        w_stall  = w_freeze || w_bubble;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex        <= '0;
            r_mem       <= '0;
            r_tcnt      <= '0;
            r_mem_err   <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            if (!w_freeze) begin
                r_mem <= r_ex;
                r_ex  <= (bus.dec_valid && !w_bubble && !w_flush) ? w_dec_slot : '0;
            end
            if (w_wait_entry)                        r_tcnt <= '0;
            else if (r_state == WAIT && !bus.mem_ack) r_tcnt <= r_tcnt + TO_W'(1);
            if (w_timeout) r_mem_err <= 1'b1;
            if (w_stall && (r_stall_cnt != {CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign bus.stall_fe  = w_stall;
    assign bus.bubble_ex = w_bubble;
    assign bus.flush_dec = w_flush;
    assign bus.freeze    = w_freeze;
    assign bus.mem_req   = w_mem_req;
    assign bus.mem_err   = r_mem_err;
    assign bus.fwd_a     = w_fwd_a;
    assign bus.fwd_b     = w_fwd_b;
    assign bus.stall_cnt = r_stall_cnt;
endmodule
